// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver with a one-entry colour buffer.
// New colours are applied only at frame boundaries (or at once while disabled).
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] rgb,
  input  logic        rgb_valid,
  output logic        rgb_ready,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        frame_start
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  logic [PreW-1:0] r_pre;
  logic [7:0]      r_cnt;
  logic [7:0]      r_duty_r;
  logic [7:0]      r_duty_g;
  logic [7:0]      r_duty_b;
  logic [23:0]     r_pend;
  logic            r_pend_full;
  logic            r_led_r;
  logic            r_led_g;
  logic            r_led_b;
  logic            r_frame_start;

  logic w_accept;
  logic w_tick;
  logic w_boundary;
  logic w_drain;

  assign w_accept   = rgb_valid && !r_pend_full;
  assign w_tick     = enable && (r_pre == PreMax);
  assign w_boundary = w_tick && (r_cnt == 8'hFF);
  // Accept needs an empty buffer and drain a full one, so they never coincide.
  assign w_drain    = r_pend_full && (!enable || w_boundary);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre         <= '0;
      r_cnt         <= 8'd0;
      r_duty_r      <= 8'd0;
      r_duty_g      <= 8'd0;
      r_duty_b      <= 8'd0;
      r_pend        <= 24'd0;
      r_pend_full   <= 1'b0;
      r_led_r       <= 1'b0;
      r_led_g       <= 1'b0;
      r_led_b       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend      <= rgb;
        r_pend_full <= 1'b1;
      end else if (w_drain) begin
        r_pend_full <= 1'b0;
      end

      if (w_drain) begin
        r_duty_r <= r_pend[23:16];
        r_duty_g <= r_pend[15:8];
        r_duty_b <= r_pend[7:0];
      end

      if (!enable) begin
        r_pre         <= '0;
        r_cnt         <= 8'd0;
        r_led_r       <= 1'b0;
        r_led_g       <= 1'b0;
        r_led_b       <= 1'b0;
        r_frame_start <= 1'b0;
      end else begin
        if (w_tick) begin
          r_pre <= '0;
          r_cnt <= r_cnt + 8'd1;
        end else begin
          r_pre <= r_pre + PreW'(1);
        end
        r_led_r       <= (r_cnt < r_duty_r);
        r_led_g       <= (r_cnt < r_duty_g);
        r_led_b       <= (r_cnt < r_duty_b);
        r_frame_start <= (r_cnt == 8'd0) && (r_pre == '0);
      end
    end
  end

  assign rgb_ready   = !r_pend_full;
  assign led_r       = r_led_r;
  assign led_g       = r_led_g;
  assign led_b       = r_led_b;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_rgb_pwm_driver;

  logic        clk;
  logic        rst_n;
  logic        en1, en4;
  logic [23:0] rgb1, rgb4;
  logic        val1, val4;
  logic        rdy1, rdy4;
  logic        lr1, lg1, lb1, fs1;
  logic        lr4, lg4, lb4, fs4;

  int total = 0;
  int bad   = 0;

  // Results of the most recent frame measurement
  int m_run_r, m_run_g, m_run_b;
  int m_one_r, m_one_g, m_one_b;
  bit m_fs_extra, m_fs_next, m_timeout;

  rgb_pwm_driver #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .rgb(rgb1), .rgb_valid(val1),
    .rgb_ready(rdy1), .led_r(lr1), .led_g(lg1), .led_b(lb1), .frame_start(fs1)
  );

  rgb_pwm_driver #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en4), .rgb(rgb4), .rgb_valid(val4),
    .rgb_ready(rdy4), .led_r(lr4), .led_g(lg4), .led_b(lb4), .frame_start(fs4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for ready, presents one word for a single clock. Called at a negedge.
  task automatic send_word(input bit sel, input logic [23:0] w);
    int n = 0;
    while (!(sel ? rdy4 : rdy1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL send_timeout sel=%0d word=%h", sel, w);
    end
    if (sel) begin rgb4 = w; val4 = 1'b1; end
    else     begin rgb1 = w; val1 = 1'b1; end
    @(negedge clk);
    if (sel) val4 = 1'b0; else val1 = 1'b0;
  endtask

  // Measures one frame starting at a frame_start sample (waits for it unless skip).
  task automatic measure(input bit sel, input int p, input bit skip);
    int  n = 0;
    bit  r, g, b, f;
    bit  lo_r = 0, lo_g = 0, lo_b = 0;
    m_run_r = 0; m_run_g = 0; m_run_b = 0;
    m_one_r = 0; m_one_g = 0; m_one_b = 0;
    m_fs_extra = 0; m_fs_next = 0; m_timeout = 0;
    if (!skip) begin
      do begin
        @(negedge clk);
        n++;
      end while (!(sel ? fs4 : fs1) && n < 600 * p);
      if (!(sel ? fs4 : fs1)) begin
        m_timeout = 1;
        total++; bad++;
        $display("FAIL frame_start_timeout sel=%0d", sel);
        return;
      end
    end
    for (int i = 0; i < 256 * p; i++) begin
      if (i > 0) @(negedge clk);
      r = sel ? lr4 : lr1;
      g = sel ? lg4 : lg1;
      b = sel ? lb4 : lb1;
      f = sel ? fs4 : fs1;
      if (i > 0 && f) m_fs_extra = 1;
      if (r) m_one_r++; else lo_r = 1;
      if (g) m_one_g++; else lo_g = 1;
      if (b) m_one_b++; else lo_b = 1;
      if (r && !lo_r) m_run_r++;
      if (g && !lo_g) m_run_g++;
      if (b && !lo_b) m_run_b++;
    end
    @(negedge clk);
    m_fs_next = sel ? fs4 : fs1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({lr1, lg1, lb1} !== 3'b000) begin bad++; $display("FAIL rst_leds got=%b exp=000", {lr1, lg1, lb1}); end
    total++; if (fs1 !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b exp=0", fs1); end
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", rdy1); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({lr1, lg1, lb1, fs1} !== 4'b0000) begin bad++; $display("FAIL post_rst_idle got=%b exp=0000", {lr1, lg1, lb1, fs1}); end
  endtask

  // Checks the captured frame against expected run lengths (run == count, from frame_start)
  task automatic check_frame(input string nm, input int er, input int eg, input int eb);
    total++;
    if (m_run_r !== er || m_one_r !== er) begin bad++; $display("FAIL %s_r run=%0d ones=%0d exp=%0d", nm, m_run_r, m_one_r, er); end
    total++;
    if (m_run_g !== eg || m_one_g !== eg) begin bad++; $display("FAIL %s_g run=%0d ones=%0d exp=%0d", nm, m_run_g, m_one_g, eg); end
    total++;
    if (m_run_b !== eb || m_one_b !== eb) begin bad++; $display("FAIL %s_b run=%0d ones=%0d exp=%0d", nm, m_run_b, m_one_b, eb); end
    total++;
    if (m_fs_extra !== 1'b0 || m_fs_next !== 1'b1) begin
      bad++; $display("FAIL %s_frame extra_fs=%0d next_fs=%0d exp=0/1", nm, m_fs_extra, m_fs_next);
    end
  endtask

  task automatic test_basic;
    en1 = 1'b1;
    repeat (10) @(negedge clk);
    send_word(0, 24'hFF8000);
    measure(0, 1, 0);
    check_frame("basic", 255, 128, 0);
  endtask

  task automatic test_extremes;
    send_word(0, 24'h000000);
    measure(0, 1, 0);
    check_frame("duty0", 0, 0, 0);
    send_word(0, 24'h010101);
    measure(0, 1, 0);
    check_frame("duty1", 1, 1, 1);
  endtask

  task automatic test_back_to_back;
    int n = 0;
    send_word(0, 24'h404040);
    total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL b2b_ready_low got=%b exp=0", rdy1); end
    rgb1 = 24'hC0C0C0;
    val1 = 1'b1;
    while (!rdy1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n < 100 || n >= 600) begin bad++; $display("FAIL b2b_stall cycles=%0d exp=100..599", n); end
    @(posedge clk);
    #1 val1 = 1'b0;
    total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL b2b_second_held got=%b exp=0", rdy1); end
    measure(0, 1, 0);
    check_frame("b2b_n1", 64, 64, 64);
    measure(0, 1, 1);
    check_frame("b2b_n2", 192, 192, 192);
    measure(0, 1, 1);
    check_frame("b2b_n3", 192, 192, 192);
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL b2b_drained got=%b exp=1", rdy1); end
  endtask

  task automatic test_enable_toggle;
    total++; if (lr1 !== 1'b1) begin bad++; $display("FAIL tog_pre_high got=%b exp=1", lr1); end
    en1 = 1'b0;
    @(negedge clk);
    total++; if ({lr1, lg1, lb1, fs1} !== 4'b0000) begin bad++; $display("FAIL tog_off got=%b exp=0000", {lr1, lg1, lb1, fs1}); end
    send_word(0, 24'h20FF00);
    repeat (2) @(negedge clk);
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL tog_loaded_ready got=%b exp=1", rdy1); end
    total++; if ({lr1, lg1, lb1, fs1} !== 4'b0000) begin bad++; $display("FAIL tog_still_off got=%b exp=0000", {lr1, lg1, lb1, fs1}); end
    en1 = 1'b1;
    @(negedge clk);
    total++; if (fs1 !== 1'b1) begin bad++; $display("FAIL tog_fs_rise got=%b exp=1", fs1); end
    measure(0, 1, 1);
    check_frame("tog", 32, 255, 0);
  endtask

  task automatic test_prescale;
    send_word(1, 24'h400000);
    repeat (2) @(negedge clk);
    en4 = 1'b1;
    @(negedge clk);
    total++; if (fs4 !== 1'b1) begin bad++; $display("FAIL pre_fs_rise got=%b exp=1", fs4); end
    measure(1, 4, 1);
    check_frame("pre4", 256, 0, 0);
  endtask

  task automatic test_async_reset;
    send_word(0, 24'h0000FF);
    total++; if (lg1 !== 1'b1) begin bad++; $display("FAIL arst_pre_high got=%b exp=1", lg1); end
    total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL arst_pending got=%b exp=0", rdy1); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({lr1, lg1, lb1, fs1} !== 4'b0000) begin bad++; $display("FAIL arst_async got=%b exp=0000", {lr1, lg1, lb1, fs1}); end
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", rdy1); end
    total++; if ({lr4, lg4, lb4, fs4} !== 4'b0000) begin bad++; $display("FAIL arst_async4 got=%b exp=0000", {lr4, lg4, lb4, fs4}); end
    @(negedge clk);
    rst_n = 1'b1;
    measure(0, 1, 0);
    check_frame("arst_discard", 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    en1 = 1'b0; en4 = 1'b0;
    rgb1 = 24'd0; rgb4 = 24'd0;
    val1 = 1'b0; val4 = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_enable_toggle();
    test_prescale();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
